fixed_mult_pipe: RTL and testbench
==================================

FIXED_MULT_PIPE -- requirements
Module: fixed_mult_pipe

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of each operand and result word: sign-magnitude, bit DATA_W-1 is the sign, the rest is the magnitude.
REQ-002 Parameter FRAC_BITS, default 13, SHALL set the fraction bits and the product right-shift amount (1 <= FRAC_BITS <= 2*DATA_W-3).
REQ-003 Parameter LANES, default 1, SHALL set the number of independent multiplier lanes sharing one handshake.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mark a, b as valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts input this cycle.
REQ-008 a  input  LANES*DATA_W  SHALL carry operand A per lane; lane i is bits [i*DATA_W +: DATA_W].
REQ-009 b  input  LANES*DATA_W  SHALL carry operand B per lane, packed as a.
REQ-010 out_valid  output  1  SHALL mark result and ovf as valid.
REQ-011 out_ready  input  1  SHALL indicate the downstream consumer accepts output this cycle.
REQ-012 result  output  LANES*DATA_W  SHALL carry the sign-magnitude product per lane.
REQ-013 ovf  output  LANES  SHALL flag that the lane's result was saturated.

Function
REQ-014 Pipeline SHALL have 3 stages: S1 registers operands; S2 registers the sign (a[MSB]^b[MSB]) and the magnitude product of width 2*(DATA_W-1); S3 registers the shifted, saturated result.
REQ-015 Latency SHALL be exactly 3 cycles from the accept edge (in_valid && in_ready) to out_valid when there is no backpressure.
REQ-016 The advance enable SHALL be adv = !out_valid || out_ready; all stages move together when adv=1 and hold when adv=0.
REQ-017 in_ready SHALL equal adv, combinationally; no input is lost or duplicated under any out_ready pattern.
REQ-018 Stage valid bits SHALL propagate bubbles; an empty slot SHALL never raise out_valid.
REQ-019 Magnitude SHALL be the product >> FRAC_BITS (truncation when FIXED_MULT_ROUND_EN is absent).
REQ-020 If the shifted magnitude exceeds 2^(DATA_W-1)-1, the lane SHALL output max magnitude with the computed sign and set ovf=1; otherwise ovf=0.
REQ-021 A zero result magnitude SHALL force sign=0 (no negative zero), including when either input is -0.
REQ-022 Lanes SHALL be fully independent in arithmetic and share only valid/ready.
REQ-023 result and ovf SHALL hold stable while out_valid && !out_ready.

Reset
REQ-024 When rst_n=0, all stage valid bits SHALL clear immediately, and out_valid=0, result=0, ovf=0.
REQ-025 Data in flight at reset SHALL be discarded; in_ready SHALL be 1 from the first cycle after release.

Configuration
REQ-026 With macro FIXED_MULT_ROUND_EN defined, S3 SHALL add 2^(FRAC_BITS-1) to the magnitude before shifting (round half up on magnitude), then apply saturation; without it, S3 SHALL truncate.

Structure
REQ-027 Package fixed_mult_pkg SHALL hold the default DATA_W/FRAC_BITS constants and a function computing shift, round and saturate for one lane.
REQ-028 One sub-module, fixed_mult_lane (S2 multiply plus S3 post-process for one lane), SHALL be instantiated LANES times; handshake logic stays in the top.

Verification (DATA_W=16, FRAC_BITS=13, LANES=1 unless noted)
REQ-029 a=0x2000, b=0x2000, out_ready=1 -> result 0x2000, ovf=0, out_valid exactly 3 cycles after accept.
REQ-030 a=0xA000, b=0x2000 -> 0xA000; a=0x8000, b=0x1234 -> 0x0000 (not 0x8000).
REQ-031 a=0x7FFF, b=0x7FFF -> 0x7FFF, ovf=1; a=0xFFFF, b=0x7FFF -> 0xFFFF, ovf=1.
REQ-032 a=0x0001, b=0x1000 -> 0x0000 without FIXED_MULT_ROUND_EN, 0x0001 with it.
REQ-033 Stream 20 random vectors with random out_ready (LANES=4) -> outputs in order, none dropped or duplicated, results held while stalled, in_ready=0 only when out_valid && !out_ready.
REQ-034 Assert rst_n low with 3 items in flight -> out_valid=0 asynchronously, no stale output after release, next accepted item appears 3 cycles later.

Source files
------------

// File: rtl/fixed_mult_pkg.sv
// Shared constants and per-lane post-processing for fixed_mult_pipe.
package fixed_mult_pkg;

   localparam int DEF_DATA_W    = 16;
   localparam int DEF_FRAC_BITS = 13;

   typedef struct packed {
      logic        ovf;
      logic [63:0] mag;
   } post_t;

   // Shift (optionally rounding half up) then saturate to mag_w bits.
   function automatic post_t shift_round_sat(
      input logic [63:0] prod,
      input int          frac_bits,
      input int          mag_w,
      input logic        rnd_en
   );
      post_t       r;
      logic [64:0] sum;
      logic [64:0] sh;
      logic [64:0] max;
      sum = {1'b0, prod};
      if (rnd_en)
         sum = sum + (65'd1 << (frac_bits - 1));
      sh    = sum >> frac_bits;
      max   = (65'd1 << mag_w) - 65'd1;
      r.ovf = (sh > max);
      r.mag = r.ovf ? max[63:0] : sh[63:0];
      return r;
   endfunction

endpackage

// File: rtl/fixed_mult_lane.sv
// One sign-magnitude lane: S2 multiply, S3 shift/round/saturate.
// FIXED_MULT_ROUND_EN selects round-half-up instead of truncation.
module fixed_mult_lane
   import fixed_mult_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FRAC_BITS = DEF_FRAC_BITS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              ovf
);

   localparam int MAG_W  = DATA_W - 1;
   localparam int PROD_W = 2 * MAG_W;

`ifdef FIXED_MULT_ROUND_EN
   localparam logic RND_EN = 1'b1;
`else
   localparam logic RND_EN = 1'b0;
`endif

   logic              sign_d, sign_q;
   logic [PROD_W-1:0] prod_d, prod_q;
   logic [DATA_W-1:0] res_d, res_q;
   logic              ovf_d, ovf_q;
   post_t             pp;

   always_comb begin
      sign_d = sign_q;
      prod_d = prod_q;
      res_d  = res_q;
      ovf_d  = ovf_q;
      pp     = shift_round_sat(64'(prod_q), FRAC_BITS, MAG_W, RND_EN);
      if (en) begin
         sign_d = a[DATA_W-1] ^ b[DATA_W-1];
         prod_d = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
         ovf_d  = pp.ovf;
         // a zero magnitude never carries a sign
         res_d  = {sign_q & (|pp.mag), pp.mag[MAG_W-1:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         prod_q <= '0;
         res_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sign_q <= sign_d;
         prod_q <= prod_d;
         res_q  <= res_d;
         ovf_q  <= ovf_d;
      end
   end

   assign result = res_q;
   assign ovf    = ovf_q;

endmodule

// File: rtl/fixed_mult_pipe.sv
// 3-stage multi-lane sign-magnitude fixed-point multiplier, valid/ready.
// Optional FIXED_MULT_ROUND_EN enables rounding in every lane.
module fixed_mult_pipe
   import fixed_mult_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int LANES     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*DATA_W-1:0] a,
   input  logic [LANES*DATA_W-1:0] b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] result,
   output logic [LANES-1:0]        ovf
);

   localparam int W = LANES * DATA_W;

   logic         adv;
   logic         v1_d, v1_q;
   logic         v2_d, v2_q;
   logic         v3_d, v3_q;
   logic [W-1:0] a_d, a_q;
   logic [W-1:0] b_d, b_q;

   // whole pipe moves as one; stalls only when the output is blocked
   always_comb begin
      adv      = !v3_q || out_ready;
      in_ready = adv;
      v1_d     = v1_q;
      v2_d     = v2_q;
      v3_d     = v3_q;
      a_d      = a_q;
      b_d      = b_q;
      if (adv) begin
         v1_d = in_valid;
         v2_d = v1_q;
         v3_d = v2_q;
         a_d  = a;
         b_d  = b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         v3_q <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
      end else begin
         v1_q <= v1_d;
         v2_q <= v2_d;
         v3_q <= v3_d;
         a_q  <= a_d;
         b_q  <= b_d;
      end
   end

   assign out_valid = v3_q;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      fixed_mult_lane #(
         .DATA_W   (DATA_W),
         .FRAC_BITS(FRAC_BITS)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (adv),
         .a     (a_q[g*DATA_W +: DATA_W]),
         .b     (b_q[g*DATA_W +: DATA_W]),
         .result(result[g*DATA_W +: DATA_W]),
         .ovf   (ovf[g])
      );
   end

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Bench for fixed_mult_pipe: directed table on a 1-lane instance,
// random backpressured stream on a 4-lane instance, reset in flight.
module tb_fixed_mult_pipe;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid1, in_ready1, out_valid1, out_ready1;
   logic [15:0] a1, b1, result1;
   logic [0:0]  ovf1;

   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [63:0] a4, b4, result4;
   logic [3:0]  ovf4;

   fixed_mult_pipe #(.DATA_W(16), .FRAC_BITS(13), .LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .result(result1), .ovf(ovf1)
   );

   fixed_mult_pipe #(.DATA_W(16), .FRAC_BITS(13), .LANES(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .ovf(ovf4)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [67:0] act,
                        input logic [67:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: real-valued fixed-point product, truncated or rounded,
   // clipped to the largest magnitude; returns {ovf, result}.
   function automatic logic [16:0] ref_mul(input logic [15:0] x,
                                           input logic [15:0] y);
      longint p;
      logic   o;
      logic   neg;
      p = longint'(x[14:0]) * longint'(y[14:0]);
`ifdef FIXED_MULT_ROUND_EN
      p = p + 4096;
`endif
      p = p / 8192;
      o = 1'b0;
      if (p > 32767) begin
         p = 32767;
         o = 1'b1;
      end
      neg = (x[15] ^ y[15]) && (p != 0);
      return {o, neg, 15'(p)};
   endfunction

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        ovf;
   } vec_t;

   vec_t tbl[9];

   task automatic run1(input logic [15:0] xa, input logic [15:0] xb,
                       output logic [15:0] r, output logic o,
                       output int lat);
      @(negedge clk);
      a1 = xa;
      b1 = xb;
      in_valid1 = 1'b1;
      out_ready1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      lat = 1;
      while (!out_valid1 && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = result1;
      o = ovf1[0];
   endtask

   logic [15:0] r;
   logic        o;
   int          lat;
   logic [67:0] q[$];
   logic [67:0] exp_w;
   logic [67:0] prev_data;
   logic        prev_stall;
   int          sent, recv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{16'h2000, 16'h2000, 16'h2000, 1'b0};
      tbl[1] = '{16'hA000, 16'h2000, 16'hA000, 1'b0};
      tbl[2] = '{16'h8000, 16'h1234, 16'h0000, 1'b0};
      tbl[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
      tbl[4] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 1'b1};
`ifdef FIXED_MULT_ROUND_EN
      tbl[5] = '{16'h0001, 16'h1000, 16'h0001, 1'b0};
`else
      tbl[5] = '{16'h0001, 16'h1000, 16'h0000, 1'b0};
`endif
      tbl[6] = '{16'h1234, 16'h8000, 16'h0000, 1'b0};
      tbl[7] = '{16'hC000, 16'hC000, 16'h7FFF, 1'b1};
      tbl[8] = '{16'h9000, 16'h2000, 16'h9000, 1'b0};

      rst_n = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
      #3;
      check("rst_out_valid1", 68'(out_valid1), 68'd0);
      check("rst_result1", 68'({ovf1, result1}), 68'd0);
      check("rst_out_valid4", 68'(out_valid4), 68'd0);
      check("rst_result4", 68'({ovf4, result4}), 68'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready1", 68'(in_ready1), 68'd1);

      for (int i = 0; i < 9; i++) begin
         run1(tbl[i].a, tbl[i].b, r, o, lat);
         check($sformatf("tbl%0d_result", i), 68'(r), 68'(tbl[i].res));
         check($sformatf("tbl%0d_ovf", i), 68'(o), 68'(tbl[i].ovf));
         check($sformatf("tbl%0d_latency", i), 68'(lat), 68'd3);
      end

      // random 4-lane stream with random backpressure
      sent = 0;
      recv = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int cyc = 0; cyc < 800 && recv < 20; cyc++) begin
         @(negedge clk);
         out_ready4 = ($urandom_range(0, 2) != 0);
         in_valid4 = (sent < 20) && ($urandom_range(0, 3) != 0);
         a4 = {$urandom, $urandom};
         b4 = {$urandom, $urandom};
         #1;
         if (!in_ready4)
            check("stream_in_ready_low", 68'(out_valid4 && !out_ready4),
                  68'd1);
         else
            check("stream_in_ready_high", 68'(out_valid4 && !out_ready4),
                  68'd0);
         if (prev_stall) begin
            check("stream_hold_valid", 68'(out_valid4), 68'd1);
            check("stream_hold_data", {ovf4, result4}, prev_data);
         end
         if (out_valid4 && out_ready4) begin
            if (q.size() == 0)
               check("stream_spurious", 68'd1, 68'(q.size()));
            else
               check("stream_result", {ovf4, result4}, q.pop_front());
            recv++;
         end
         if (in_valid4 && in_ready4) begin
            exp_w = '0;
            for (int l = 0; l < 4; l++) begin
               logic [16:0] e;
               e = ref_mul(a4[l*16 +: 16], b4[l*16 +: 16]);
               exp_w[l*16 +: 16] = e[15:0];
               exp_w[64 + l] = e[16];
            end
            q.push_back(exp_w);
            sent++;
         end
         prev_stall = out_valid4 && !out_ready4;
         prev_data = {ovf4, result4};
      end
      in_valid4 = 1'b0;
      check("stream_recv_count", 68'(recv), 68'd20);
      check("stream_leftover", 68'(q.size()), 68'd0);

      // reset with three items in flight
      @(negedge clk);
      out_ready1 = 1'b0;
      in_valid1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         a1 = 16'h2000 + 16'(k);
         b1 = 16'h2000;
         @(posedge clk);
         #1;
      end
      in_valid1 = 1'b0;
      check("flight_full_valid", 68'(out_valid1), 68'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 68'(out_valid1), 68'd0);
      check("async_rst_data", 68'({ovf1, result1}), 68'd0);
      @(negedge clk);
      out_ready1 = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("post_rst_no_stale", 68'(out_valid1), 68'd0);
         check("post_rst_in_ready", 68'(in_ready1), 68'd1);
         @(negedge clk);
      end
      run1(16'hA000, 16'hA000, r, o, lat);
      check("post_rst_result", 68'(r), 68'h2000);
      check("post_rst_latency", 68'(lat), 68'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
